// File: rtl/pe_loop_cntl.sv
`default_nettype none
// ============================================================================
// Module   : pe_loop_cntl
// Purpose  : Per-PE loop-nest controller sequencing STREAM -> EXEC -> PPU for
//            each conv layer. Optional perf counters: PE_LOOP_CNTL_PERF_EN.
// Revision : 1.0
// ============================================================================
module pe_loop_cntl #(
  parameter int NUM_LAYERS = 8,
  parameter int MAX_K      = 64,
  parameter int MAX_C      = 256,
  parameter int MAX_A      = 1024,
  parameter int MAX_W      = 512,
  parameter int F          = 4,
  parameter int I          = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [$clog2(NUM_LAYERS+1)-1:0]   cfg_num_layers,
  input  logic [$clog2(MAX_K+1)-1:0]        cfg_k_cnt,
  input  logic [$clog2(MAX_C+1)-1:0]        cfg_c_cnt,
  input  logic [$clog2(MAX_W+1)-1:0]        cfg_w_cnt,
  input  logic [$clog2(MAX_A+1)-1:0]        cfg_a_cnt_dense,
  input  logic [$clog2(MAX_A+1)-1:0]        cfg_a_cnt_sparse,
  input  logic                              ppu_sparse,
  output logic                              req_filter_valid,
  output logic [$clog2(MAX_K)-1:0]          req_filter_k,
  output logic [$clog2(NUM_LAYERS)-1:0]     req_layer,
  output logic                              req_input_valid,
  input  logic                              filter_done,
  input  logic                              input_done,
  output logic                              ex_valid,
  input  logic                              ex_ready,
  output logic [$clog2(MAX_K+1)-1:0]        ex_k,
  output logic [$clog2(MAX_C+1)-1:0]        ex_c,
  output logic [$clog2(MAX_A+1)-1:0]        ex_a,
  output logic [$clog2(MAX_W+1)-1:0]        ex_w,
  output logic                              ex_last,
  output logic                              cur_sparse,
  output logic                              ppu_start,
  input  logic                              ppu_done,
`ifdef PE_LOOP_CNTL_PERF_EN
  output logic [31:0]                       perf_exec_beats,
  output logic [31:0]                       perf_stall_cycles,
`endif
  output logic                              busy,
  output logic                              all_done
);

  localparam int LW = $clog2(NUM_LAYERS+1);
  localparam int KW = $clog2(MAX_K+1);
  localparam int CW = $clog2(MAX_C+1);
  localparam int AW = $clog2(MAX_A+1);
  localparam int WW = $clog2(MAX_W+1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_EXEC   = 2'd2;
  localparam logic [1:0] ST_PPU    = 2'd3;

  logic [1:0]    state;
  logic [LW-1:0] layer, num_layers_q;
  logic [KW-1:0] k, k_cnt_q;
  logic [CW-1:0] c, c_cnt_q;
  logic [AW-1:0] a, a_cnt_q;
  logic [WW-1:0] w, w_cnt_q;
  logic          sparse_q;
  logic          filter_seen, input_seen;
  logic          ex_valid_q, ppu_start_q, all_done_q;

  logic          filter_ok, input_ok;
  logic          w_wrap, a_wrap, c_wrap, last_beat, accept;
  logic          k_more, layer_more, layer_start;
  logic [AW-1:0] a_sel;

  assign req_filter_valid = (state == ST_STREAM);
  assign req_input_valid  = (state == ST_STREAM) && (layer == '0) && (k == '0);
  assign req_filter_k     = k[$clog2(MAX_K)-1:0];
  assign req_layer        = layer[$clog2(NUM_LAYERS)-1:0];
  assign ex_valid         = ex_valid_q;
  assign ex_k             = k;
  assign ex_c             = c;
  assign ex_a             = a;
  assign ex_w             = w;
  assign ex_last          = ex_valid_q && last_beat;
  assign cur_sparse       = sparse_q;
  assign ppu_start        = ppu_start_q;
  assign all_done         = all_done_q;
  assign busy             = (state != ST_IDLE);

  // A done pulse in the exit cycle counts; no input request means nothing to wait for.
  assign filter_ok = filter_seen || filter_done;
  assign input_ok  = input_seen || input_done || !req_input_valid;

  // Widened by one bit so the step addition can never wrap around.
  assign w_wrap    = ({1'b0, w} + (WW+1)'(F)) >= {1'b0, w_cnt_q};
  assign a_wrap    = ({1'b0, a} + (AW+1)'(I)) >= {1'b0, a_cnt_q};
  assign c_wrap    = ({1'b0, c} + (CW+1)'(1)) >= {1'b0, c_cnt_q};
  assign last_beat = w_wrap && a_wrap && c_wrap;
  assign accept    = ex_valid_q && ex_ready;

  assign k_more     = ({1'b0, k} + (KW+1)'(1)) < {1'b0, k_cnt_q};
  assign layer_more = ({1'b0, layer} + (LW+1)'(1)) < {1'b0, num_layers_q};
  assign layer_start = ((state == ST_IDLE) && start) ||
                       ((state == ST_PPU) && !all_done_q && ppu_done && layer_more);

  assign a_sel = ppu_sparse ? cfg_a_cnt_sparse : cfg_a_cnt_dense;

  // Layer configuration is frozen for the whole layer; zero counts behave as one.
  always_ff @(posedge clk) begin
    if (rst) begin
      num_layers_q <= '0;
      k_cnt_q      <= '0;
      c_cnt_q      <= '0;
      a_cnt_q      <= '0;
      w_cnt_q      <= '0;
      sparse_q     <= 1'b0;
    end else if (layer_start) begin
      num_layers_q <= (cfg_num_layers == '0) ? LW'(1) : cfg_num_layers;
      k_cnt_q      <= (cfg_k_cnt == '0) ? KW'(1) : cfg_k_cnt;
      c_cnt_q      <= (cfg_c_cnt == '0) ? CW'(1) : cfg_c_cnt;
      a_cnt_q      <= (a_sel == '0) ? AW'(1) : a_sel;
      w_cnt_q      <= (cfg_w_cnt == '0) ? WW'(1) : cfg_w_cnt;
      sparse_q     <= ppu_sparse;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      layer       <= '0;
      k           <= '0;
      c           <= '0;
      a           <= '0;
      w           <= '0;
      ex_valid_q  <= 1'b0;
      ppu_start_q <= 1'b0;
      all_done_q  <= 1'b0;
      filter_seen <= 1'b0;
      input_seen  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_STREAM;
            layer <= '0;
            k     <= '0;
          end
        end
        ST_STREAM: begin
          if (filter_ok && input_ok) begin
            state       <= ST_EXEC;
            ex_valid_q  <= 1'b1;
            filter_seen <= 1'b0;
            input_seen  <= 1'b0;
            c           <= '0;
            a           <= '0;
            w           <= '0;
          end else begin
            filter_seen <= filter_ok;
            input_seen  <= input_seen || input_done;
          end
        end
        ST_EXEC: begin
          if (accept) begin
            if (last_beat) begin
              ex_valid_q <= 1'b0;
              c          <= '0;
              a          <= '0;
              w          <= '0;
              if (k_more) begin
                k     <= k + KW'(1);
                state <= ST_STREAM;
              end else begin
                state       <= ST_PPU;
                ppu_start_q <= 1'b1;
              end
            end else begin
              w <= w_wrap ? '0 : w + WW'(F);
              if (w_wrap) a <= a_wrap ? '0 : a + AW'(I);
              if (w_wrap && a_wrap) c <= c_wrap ? '0 : c + CW'(1);
            end
          end
        end
        ST_PPU: begin
          ppu_start_q <= 1'b0;
          // all_done is held for one cycle while still busy, then IDLE.
          if (all_done_q) begin
            all_done_q <= 1'b0;
            state      <= ST_IDLE;
            layer      <= '0;
            k          <= '0;
          end else if (ppu_done) begin
            if (layer_more) begin
              layer <= layer + LW'(1);
              k     <= '0;
              state <= ST_STREAM;
            end else begin
              all_done_q <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef PE_LOOP_CNTL_PERF_EN
  logic [31:0] beats_q, stalls_q;

  always_ff @(posedge clk) begin
    if (rst || ((state == ST_IDLE) && start)) begin
      beats_q  <= '0;
      stalls_q <= '0;
    end else begin
      if (accept && (beats_q != '1)) beats_q <= beats_q + 32'd1;
      if (ex_valid_q && !ex_ready && (stalls_q != '1)) stalls_q <= stalls_q + 32'd1;
    end
  end

  assign perf_exec_beats   = beats_q;
  assign perf_stall_cycles = stalls_q;
`else
  // Control path only; no counter state exists in this build.
`endif

endmodule
`default_nettype wire
